smem_store_unit: RTL and testbench
==================================

# smem_store_unit

Dual-bank token storage that sits directly downstream of backward-extension control stage 1. It accepts that stage's registered write ports into a 128-entry current-token bank (`curr`) and a 128-entry memory-result bank (`mem`), and serves the read-back of current tokens at `rd_addr`. At read end it drains the `mem` bank in address order through a valid/ready stream.

## Interface
Parameters:
- `DEPTH`, 128: entries per bank; address width fixed at 7.
- `W`, 64: width of each token word.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: pipeline stall; freezes the read port.
- `store_valid_mem` in 1; `mem_x_0`, `mem_x_1`, `mem_x_2`, `mem_x_info` in 64 each; `mem_x_addr` in 7: `mem` bank write.
- `store_valid_curr` in 1; `curr_x_0`, `curr_x_1`, `curr_x_2`, `curr_x_info` in 64 each; `curr_x_addr` in 7: `curr` bank write.
- `rd_en` in 1; `rd_addr` in 7: `curr` bank read request.
- `rd_valid` out 1; `rd_x_0`, `rd_x_1`, `rd_x_2`, `rd_x_info` out 64 each: read data.
- `drain_start` in 1; `drain_count` in 7: start a drain of `mem[0 .. drain_count-1]`.
- `drain_valid` out 1; `drain_ready` in 1; `drain_x_0`, `drain_x_1`, `drain_x_2`, `drain_x_info` out 64 each; `drain_last` out 1: drain stream.
- `drain_done` out 1: one-cycle pulse when a drain completes.
- `busy` out 1: FSM is not IDLE.
- `err_wr_in_drain` out 1: sticky flag; cleared only by `rst`.

## Operation
Writes:
- Any cycle with `store_valid_curr`=1 writes all four words to `curr[curr_x_addr]`, even while `stall`=1. Repeated held writes are idempotent.
- The same rule applies to `store_valid_mem` and the `mem` bank.
- `mem` and `curr` writes in the same cycle are independent.
- A `mem` write while `busy`=1 is dropped and sets `err_wr_in_drain`.

Read port:
- `rd_en`=1 with `stall`=0 in cycle N loads `curr[rd_addr]` into the `rd_x_*` registers and sets `rd_valid`=1 in cycle N+1.
- `rd_en`=0 with `stall`=0 clears `rd_valid` and leaves the data registers unchanged.
- `stall`=1 holds `rd_valid` and `rd_x_*` and ignores `rd_en`.

Drain FSM (states IDLE, FETCH, SHOW; index register `idx`, 7 bits):
- IDLE: on `drain_start`=1 with `drain_count`=0, pulse `drain_done` next cycle and stay in IDLE.
- IDLE: on `drain_start`=1 with `drain_count`>0, latch the count, set `idx`=0, go to FETCH.
- FETCH: load `mem[idx]` into `drain_x_*`, set `drain_valid`=1, set `drain_last`=(`idx`==count-1), go to SHOW.
- SHOW: hold all drain outputs while `drain_ready`=0.
- SHOW on handshake (`drain_valid` & `drain_ready`): clear `drain_valid`.
  - If `drain_last`: pulse `drain_done` next cycle, go to IDLE.
  - Otherwise: `idx`+1, go to FETCH.
- `drain_start` outside IDLE is ignored.
- `drain_x_info` carries the full stored `mem_x_info` word; the high 32 bits hold the start position.

Reset and initialisation:
- Every output is 0 after reset, the FSM is IDLE and `idx`=0.
- Bank contents are not reset. A read of an unwritten entry returns X.
- `rst` in the middle of a drain aborts it: `drain_valid`=0 the next cycle and no `drain_done`.

## Timing
- Read latency: 1 cycle from an accepted `rd_en` to `rd_valid`.
- Drain first beat: `drain_valid` rises 2 cycles after `drain_start`.
- Drain throughput: 1 beat per 2 cycles with `drain_ready` held high. N entries finish with `drain_done` 2N+1 cycles after `drain_start`.
- `drain_done` is high for exactly one cycle.
- `busy` is 1 from the cycle after `drain_start` until the cycle `drain_done` is high.
- All address arithmetic is 7-bit; `idx` never exceeds 126 because the latched count is at most 127.

## Configuration
- `STORE_BYPASS_EN` defined: a same-cycle `store_valid_curr` write with `curr_x_addr`==`rd_addr` and an accepted `rd_en` returns the newly written words at N+1.
- `STORE_BYPASS_EN` undefined: that case returns the bank contents from before the write. The write still lands, and a read in cycle N+1 returns the new data.

## Test plan
- Write `curr[5]`={1,2,3,4}, then in the next cycle `rd_en`, `rd_addr`=5 -> `rd_valid`=1 and `rd_x_*`={1,2,3,4} one cycle later.
- Bypass: write `curr[9]`={A,B,C,D} in the same cycle as a read of 9 -> {A,B,C,D} with `STORE_BYPASS_EN`; old contents without it.
- Stall: a read is pending and `stall`=1 for 3 cycles with `rd_addr` changing -> `rd_x_*` and `rd_valid` unchanged for those 3 cycles.
- Write `mem[0..2]`, then `drain_start`, `drain_count`=3 with `drain_ready`=1 -> 3 beats in order, `drain_last` on beat 3, `drain_done` at cycle 7.
- `drain_count`=0 -> `drain_done` pulse after 1 cycle and `drain_valid` never 1. `drain_ready`=0 for 4 cycles mid-drain -> beat held stable.
- `mem` write during a drain -> `err_wr_in_drain`=1 and the drained data unchanged. `rst` mid-drain -> `drain_valid`=0 next cycle and no `drain_done`.

Source files
------------

// File: rtl/smem_store_unit.sv
// Dual-bank token store: curr bank with a 1-cycle read port, mem bank drained in order over valid/ready.
// Optional macro STORE_BYPASS_EN forwards a same-cycle curr write to a matching read.
module smem_store_unit #(
    parameter int DEPTH = 128,
    parameter int W     = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_stall,

    input  logic         i_store_valid_mem,
    input  logic [W-1:0] i_mem_x_0,
    input  logic [W-1:0] i_mem_x_1,
    input  logic [W-1:0] i_mem_x_2,
    input  logic [W-1:0] i_mem_x_info,
    input  logic [6:0]   i_mem_x_addr,

    input  logic         i_store_valid_curr,
    input  logic [W-1:0] i_curr_x_0,
    input  logic [W-1:0] i_curr_x_1,
    input  logic [W-1:0] i_curr_x_2,
    input  logic [W-1:0] i_curr_x_info,
    input  logic [6:0]   i_curr_x_addr,

    input  logic         i_rd_en,
    input  logic [6:0]   i_rd_addr,
    output logic         o_rd_valid,
    output logic [W-1:0] o_rd_x_0,
    output logic [W-1:0] o_rd_x_1,
    output logic [W-1:0] o_rd_x_2,
    output logic [W-1:0] o_rd_x_info,

    input  logic         i_drain_start,
    input  logic [6:0]   i_drain_count,
    output logic         o_drain_valid,
    input  logic         i_drain_ready,
    output logic [W-1:0] o_drain_x_0,
    output logic [W-1:0] o_drain_x_1,
    output logic [W-1:0] o_drain_x_2,
    output logic [W-1:0] o_drain_x_info,
    output logic         o_drain_last,
    output logic         o_drain_done,

    output logic         o_busy,
    output logic         o_err_wr_in_drain
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    // Each entry packs {info, x_2, x_1, x_0}.
    logic [4*W-1:0] r_curr_bank [DEPTH];
    logic [4*W-1:0] r_mem_bank  [DEPTH];

    state_t         r_state;
    state_t         w_state_nxt;
    logic [6:0]     r_idx;
    logic [6:0]     w_idx_nxt;
    logic [6:0]     r_cnt;
    logic [6:0]     w_cnt_nxt;
    logic           r_drain_valid;
    logic           w_drain_valid_nxt;
    logic           r_drain_last;
    logic           w_drain_last_nxt;
    logic           r_drain_done;
    logic           w_drain_done_nxt;
    logic [4*W-1:0] r_drain_word;
    logic [4*W-1:0] w_drain_word_nxt;

    logic           r_rd_valid;
    logic [4*W-1:0] r_rd_word;
    logic [4*W-1:0] w_rd_word;
    logic [4*W-1:0] w_curr_wr_word;
    logic           w_busy;
    logic           w_mem_wr_ok;
    logic           r_err;

    assign w_curr_wr_word = {i_curr_x_info, i_curr_x_2, i_curr_x_1, i_curr_x_0};

    // The done cycle still counts as busy, so a mem write landing with the done pulse is flagged.
    assign w_busy      = (r_state != S_IDLE) || r_drain_done;
    assign w_mem_wr_ok = i_store_valid_mem && !w_busy;

    always_ff @(posedge i_clk) begin
        if (i_store_valid_curr) begin
            r_curr_bank[i_curr_x_addr] <= w_curr_wr_word;
        end
        if (w_mem_wr_ok) begin
            r_mem_bank[i_mem_x_addr] <= {i_mem_x_info, i_mem_x_2, i_mem_x_1, i_mem_x_0};
        end
    end

`ifdef STORE_BYPASS_EN
    assign w_rd_word = (i_store_valid_curr && (i_curr_x_addr == i_rd_addr))
                       ? w_curr_wr_word : r_curr_bank[i_rd_addr];
`else
    assign w_rd_word = r_curr_bank[i_rd_addr];
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_valid <= 1'b0;
            r_rd_word  <= '0;
        end else if (!i_stall) begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                r_rd_word <= w_rd_word;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (i_store_valid_mem && w_busy) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_drain_valid <= 1'b0;
            r_drain_last  <= 1'b0;
            r_drain_done  <= 1'b0;
            r_drain_word  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_cnt         <= w_cnt_nxt;
            r_drain_valid <= w_drain_valid_nxt;
            r_drain_last  <= w_drain_last_nxt;
            r_drain_done  <= w_drain_done_nxt;
            r_drain_word  <= w_drain_word_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_idx_nxt         = r_idx;
        w_cnt_nxt         = r_cnt;
        w_drain_valid_nxt = r_drain_valid;
        w_drain_last_nxt  = r_drain_last;
        w_drain_done_nxt  = 1'b0;
        w_drain_word_nxt  = r_drain_word;
        case (r_state)
            S_IDLE: begin
                if (i_drain_start) begin
                    if (i_drain_count == 7'd0) begin
                        w_drain_done_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt   = i_drain_count;
                        w_idx_nxt   = 7'd0;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                w_drain_word_nxt  = r_mem_bank[r_idx];
                w_drain_valid_nxt = 1'b1;
                w_drain_last_nxt  = (r_idx == (r_cnt - 7'd1));
                w_state_nxt       = S_SHOW;
            end
            S_SHOW: begin
                if (r_drain_valid && i_drain_ready) begin
                    w_drain_valid_nxt = 1'b0;
                    w_drain_last_nxt  = 1'b0;
                    if (r_drain_last) begin
                        w_drain_done_nxt = 1'b1;
                        w_state_nxt      = S_IDLE;
                    end else begin
                        w_idx_nxt   = r_idx + 7'd1;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_rd_valid        = r_rd_valid;
    assign o_rd_x_0          = r_rd_word[W-1:0];
    assign o_rd_x_1          = r_rd_word[2*W-1:W];
    assign o_rd_x_2          = r_rd_word[3*W-1:2*W];
    assign o_rd_x_info       = r_rd_word[4*W-1:3*W];

    assign o_drain_valid     = r_drain_valid;
    assign o_drain_x_0       = r_drain_word[W-1:0];
    assign o_drain_x_1       = r_drain_word[2*W-1:W];
    assign o_drain_x_2       = r_drain_word[3*W-1:2*W];
    assign o_drain_x_info    = r_drain_word[4*W-1:3*W];
    assign o_drain_last      = r_drain_last;
    assign o_drain_done      = r_drain_done;

    assign o_busy            = w_busy;
    assign o_err_wr_in_drain = r_err;

endmodule

// File: tb/tb_smem_store_unit.sv
// Directed self-checking bench for smem_store_unit: read port, bypass, stall, drain timing, errors and reset.
module tb_smem_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        sv_mem;
    logic [63:0] m0, m1, m2, minfo;
    logic [6:0]  maddr;
    logic        sv_curr;
    logic [63:0] c0, c1, c2, cinfo;
    logic [6:0]  caddr;
    logic        rd_en;
    logic [6:0]  rd_addr;
    logic        rd_valid;
    logic [63:0] r0, r1, r2, rinfo;
    logic        dstart;
    logic [6:0]  dcount;
    logic        dvalid;
    logic        dready;
    logic [63:0] d0, d1, d2, dinfo;
    logic        dlast;
    logic        ddone;
    logic        busy;
    logic        err;

    int n_chk = 0;
    int n_err = 0;

    smem_store_unit dut (
        .i_clk(clk), .i_rst(rst), .i_stall(stall),
        .i_store_valid_mem(sv_mem), .i_mem_x_0(m0), .i_mem_x_1(m1), .i_mem_x_2(m2),
        .i_mem_x_info(minfo), .i_mem_x_addr(maddr),
        .i_store_valid_curr(sv_curr), .i_curr_x_0(c0), .i_curr_x_1(c1), .i_curr_x_2(c2),
        .i_curr_x_info(cinfo), .i_curr_x_addr(caddr),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_valid(rd_valid),
        .o_rd_x_0(r0), .o_rd_x_1(r1), .o_rd_x_2(r2), .o_rd_x_info(rinfo),
        .i_drain_start(dstart), .i_drain_count(dcount), .o_drain_valid(dvalid),
        .i_drain_ready(dready), .o_drain_x_0(d0), .o_drain_x_1(d1), .o_drain_x_2(d2),
        .o_drain_x_info(dinfo), .o_drain_last(dlast), .o_drain_done(ddone),
        .o_busy(busy), .o_err_wr_in_drain(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mword(input int i);
        logic [31:0] pos;
        logic [31:0] lo;
        pos = 32'(i * 10 + 7);
        lo  = 32'(i);
        return {pos, lo, 64'hC000 + 64'(i), 64'hB000 + 64'(i), 64'hA000 + 64'(i)};
    endfunction

    function automatic logic [255:0] rd_word();
        return {rinfo, r2, r1, r0};
    endfunction

    function automatic logic [255:0] dr_word();
        return {dinfo, d2, d1, d0};
    endfunction

    task automatic put_curr(input logic [6:0] a, input logic [255:0] w);
        sv_curr = 1'b1;
        caddr   = a;
        {cinfo, c2, c1, c0} = w;
    endtask

    task automatic put_mem(input logic [6:0] a, input logic [255:0] w);
        sv_mem = 1'b1;
        maddr  = a;
        {minfo, m2, m1, m0} = w;
    endtask

    logic [255:0] w1234, wold9, wabcd;
    int beats;
    int done_cyc;
    int done_cnt;

    initial begin
        rst = 1'b1; stall = 1'b0;
        sv_mem = 1'b0; m0 = '0; m1 = '0; m2 = '0; minfo = '0; maddr = '0;
        sv_curr = 1'b0; c0 = '0; c1 = '0; c2 = '0; cinfo = '0; caddr = '0;
        rd_en = 1'b0; rd_addr = '0; dstart = 1'b0; dcount = '0; dready = 1'b0;
        w1234 = {64'd4, 64'd3, 64'd2, 64'd1};
        wold9 = {64'd14, 64'd13, 64'd12, 64'd11};
        wabcd = {64'hD, 64'hC, 64'hB, 64'hA};
        tick(); tick();
        rst = 1'b0;

        chk("rst_rd_valid", 256'(rd_valid), 256'(0));
        chk("rst_rd_data", rd_word(), 256'(0));
        chk("rst_drain_valid", 256'(dvalid), 256'(0));
        chk("rst_drain_data", dr_word(), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_err", 256'(err), 256'(0));
        chk("rst_done", 256'(ddone), 256'(0));

        // write then read back
        put_curr(7'd5, w1234);
        tick();
        sv_curr = 1'b0;
        rd_en = 1'b1; rd_addr = 7'd5;
        tick();
        chk("rd5_valid", 256'(rd_valid), 256'(1));
        chk("rd5_data", rd_word(), w1234);
        rd_en = 1'b0;
        tick();
        chk("rd_idle_valid", 256'(rd_valid), 256'(0));
        chk("rd_idle_hold", rd_word(), w1234);

        // same-cycle write and read of entry 9
        put_curr(7'd9, wold9);
        tick();
        put_curr(7'd9, wabcd);
        rd_en = 1'b1; rd_addr = 7'd9;
        tick();
        sv_curr = 1'b0;
`ifdef STORE_BYPASS_EN
        chk("bypass_data", rd_word(), wabcd);
`else
        chk("bypass_data", rd_word(), wold9);
`endif
        tick();
        chk("post_write_data", rd_word(), wabcd);

        // stall holds the read port
        rd_addr = 7'd5;
        tick();
        chk("pre_stall_data", rd_word(), w1234);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_addr = (i == 1) ? 7'd0 : 7'd9;
            rd_en   = (i != 2);
            tick();
            chk("stall_valid", 256'(rd_valid), 256'(1));
            chk("stall_data", rd_word(), w1234);
        end
        stall = 1'b0; rd_en = 1'b0;
        tick();
        chk("unstall_valid", 256'(rd_valid), 256'(0));

        // fill mem[0..2] and drain 3 entries
        for (int i = 0; i < 3; i++) begin
            put_mem(7'(i), mword(i));
            tick();
        end
        sv_mem = 1'b0;
        dstart = 1'b1; dcount = 7'd3; dready = 1'b1;
        beats = 0; done_cyc = -1; done_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            dstart = 1'b0;
            if (c == 1) chk("busy_c1", 256'(busy), 256'(1));
            if (c == 1) chk("no_beat_c1", 256'(dvalid), 256'(0));
            if (dvalid) begin
                if (beats == 0) chk("first_beat_cycle", 256'(c), 256'(2));
                if (beats < 3) chk("beat_data", dr_word(), mword(beats));
                chk("beat_last", 256'(dlast), 256'(beats == 2));
                beats++;
            end
            if (ddone) begin
                if (done_cyc < 0) done_cyc = c;
                done_cnt++;
                chk("busy_at_done", 256'(busy), 256'(1));
            end
            if (c == 8) chk("busy_after_done", 256'(busy), 256'(0));
        end
        chk("beat_count", 256'(beats), 256'(3));
        chk("done_cycle", 256'(done_cyc), 256'(7));
        chk("done_pulses", 256'(done_cnt), 256'(1));

        // zero-length drain
        dstart = 1'b1; dcount = 7'd0;
        tick();
        dstart = 1'b0;
        chk("zero_done", 256'(ddone), 256'(1));
        chk("zero_valid", 256'(dvalid), 256'(0));
        tick();
        chk("zero_done_off", 256'(ddone), 256'(0));
        chk("zero_valid2", 256'(dvalid), 256'(0));
        chk("zero_busy_off", 256'(busy), 256'(0));

        // backpressure plus a dropped mem write during the drain
        dstart = 1'b1; dcount = 7'd2; dready = 1'b0;
        tick();
        dstart = 1'b0;
        put_mem(7'd1, {4{64'hDEAD_BEEF}});
        tick();
        sv_mem = 1'b0;
        chk("err_set", 256'(err), 256'(1));
        chk("bp_first_valid", 256'(dvalid), 256'(1));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_valid", 256'(dvalid), 256'(1));
            chk("bp_hold_data", dr_word(), mword(0));
            chk("bp_hold_last", 256'(dlast), 256'(0));
        end
        dready = 1'b1;
        tick();
        chk("bp_release_valid", 256'(dvalid), 256'(0));
        tick();
        chk("bp_beat2_valid", 256'(dvalid), 256'(1));
        chk("bp_beat2_data", dr_word(), mword(1));
        chk("bp_beat2_last", 256'(dlast), 256'(1));
        tick();
        chk("bp_done", 256'(ddone), 256'(1));
        chk("err_sticky", 256'(err), 256'(1));
        tick();

        // reset in the middle of a drain
        dstart = 1'b1; dcount = 7'd3;
        tick();
        dstart = 1'b0;
        tick();
        chk("abort_pre_valid", 256'(dvalid), 256'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", 256'(dvalid), 256'(0));
        chk("abort_busy", 256'(busy), 256'(0));
        chk("abort_err_clr", 256'(err), 256'(0));
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (ddone || dvalid) done_cnt++;
        end
        chk("abort_quiet", 256'(done_cnt), 256'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
